// File: rtl/mult_unit.sv
// mult_unit: iterative shift-add signed multiplier for the EX stage.
// It stalls the pipeline while busy and pulses done_o when result_o is valid.
module mult_unit #(
   parameter int         WIDTH     = 32,
   parameter logic [3:0] MULT_CODE = 4'b0011
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [3:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mcand, mplier, acc, sum;
   logic             sign, req;
   assign req  = valid_i && ALUCtrl_i == MULT_CODE;
   assign sum  = acc + (mplier[0] ? mcand : '0);
   // gated by rst_i so a pending request cannot raise stall while in reset
   assign stall_o = rst_i && ((state == IDLE && req && !flush_i) || state == BUSY);
   assign done_o  = state == DONE;
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         sign     <= 1'b0;
         result_o <= '0;
      end else if (flush_i) begin
         state <= IDLE;
      end else if (state == IDLE) begin
         if (req) begin
            mcand  <= src1_i[WIDTH-1] ? -src1_i : src1_i;
            mplier <= src2_i[WIDTH-1] ? -src2_i : src2_i;
            sign   <= src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            state  <= BUSY;
         end
      end else if (state == BUSY) begin
         acc    <= sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            state    <= DONE;
            result_o <= sign ? -sum : sum;
         end
      end else begin
         state <= IDLE;
      end
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed vectors with hand-computed products, latency and
// stall/done timing checks, flush, async reset and non-multiply traffic.
module tb_mult_unit;
   localparam logic [3:0] MULT = 4'b0011;
   logic        clk = 1'b0;
   logic        rst, valid, flush, stall, done;
   logic [3:0]  alu;
   logic [31:0] s1, s2, result;
   int          n_cmp = 0, n_bad = 0;

   mult_unit dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUCtrl_i(alu),
      .src1_i(s1), .src2_i(s2), .flush_i(flush),
      .stall_o(stall), .done_o(done), .result_o(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Entered just after a rising edge with the block idle; that cycle is cycle 0.
   // During DONE the next instruction (n1,n2) is presented; hold keeps it after DONE.
   task automatic mult_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit hold,
                          input logic [31:0] n1, input logic [31:0] n2);
      int st = 0, dn = 0;
      valid = 1'b1; alu = MULT; flush = 1'b0; s1 = a; s2 = b;
      for (int c = 0; c < 33; c++) begin
         @(negedge clk);
         st += int'(stall);
         dn += int'(done);
         @(posedge clk); #1;
         s1 = (c == 32) ? n1 : $urandom;
         s2 = (c == 32) ? n2 : $urandom;
      end
      @(negedge clk);
      chk({tag, " stall_cycles"}, st, 33);
      chk({tag, " early_done"}, dn, 0);
      chk({tag, " done"}, {31'b0, done}, 1);
      chk({tag, " stall_at_done"}, {31'b0, stall}, 0);
      chk({tag, " result"}, result, exp);
      @(posedge clk); #1;
      valid = hold;
      if (!hold) begin
         @(negedge clk);
         chk({tag, " idle_after_done"}, {31'b0, stall}, 0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int dn;
      rst = 1'b0; valid = 1'b0; flush = 1'b0; alu = 4'b0; s1 = '0; s2 = '0;
      #3;
      chk("rst stall", {31'b0, stall}, 0);
      chk("rst done", {31'b0, done}, 0);
      chk("rst result", result, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      mult_op("7x6", 32'd7, 32'd6, 32'd42, 1'b0, 32'd1, 32'd1);
      mult_op("-3x5", 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0, 32'd9, 32'd9);
      mult_op("min x -1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32'd2, 32'd2);
      mult_op("-7x-9", 32'hFFFFFFF9, 32'hFFFFFFF7, 32'd63, 1'b0, 32'd3, 32'd3);
      mult_op("wrap", 32'h00010000, 32'h00010000, 32'd0, 1'b0, 32'd4, 32'd4);
      mult_op("12345x-1", 32'd12345, 32'hFFFFFFFF, 32'hFFFFCFC7, 1'b0, 32'd5, 32'd5);
      mult_op("-1x-1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd6, 32'd6);

      // back-to-back: second request is already present during DONE
      mult_op("b2b first", 32'd11, 32'd13, 32'd143, 1'b1, 32'd5, 32'd5);
      mult_op("b2b second", 32'd5, 32'd5, 32'd25, 1'b0, 32'd7, 32'd7);

      // flush while idle overrides a request
      valid = 1'b1; alu = MULT; s1 = 32'd8; s2 = 32'd8; flush = 1'b1;
      @(negedge clk);
      chk("flush idle stall", {31'b0, stall}, 0);
      @(posedge clk); #1;
      flush = 1'b0; valid = 1'b0;
      @(negedge clk);
      chk("flush idle no start", {31'b0, stall}, 0);

      // flush in cycle 10 of a multiply
      @(posedge clk); #1;
      valid = 1'b1; s1 = 32'd100; s2 = 32'd100;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         s1 = $urandom;
      end
      flush = 1'b1;
      @(negedge clk);
      chk("flush busy stall", {31'b0, stall}, 1);
      @(posedge clk); #1;
      flush = 1'b0; valid = 1'b0;
      @(negedge clk);
      chk("flush cycle11 stall", {31'b0, stall}, 0);
      dn = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         dn += int'(done);
      end
      chk("flush no done", dn, 0);
      chk("flush result kept", result, 32'd25);

      // async reset in cycle 15 of a multiply, request still asserted
      @(posedge clk); #1;
      valid = 1'b1; s1 = 32'd9; s2 = 32'd9;
      for (int c = 1; c <= 15; c++) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("areset stall", {31'b0, stall}, 0);
      chk("areset done", {31'b0, done}, 0);
      chk("areset result", result, 0);
      @(posedge clk); @(posedge clk); #1;
      valid = 1'b0;
      rst = 1'b1;
      dn = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         dn += int'(done) + int'(stall);
      end
      chk("post reset quiet", dn, 0);
      @(posedge clk); #1;
      mult_op("2x3 after reset", 32'd2, 32'd3, 32'd6, 1'b0, 32'd1, 32'd1);

      // non-multiply traffic never starts the unit
      valid = 1'b1; alu = 4'b0010; s1 = 32'd4; s2 = 32'd4;
      dn = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         dn += int'(done) + int'(stall);
      end
      chk("other op quiet", dn, 0);
      @(posedge clk); #1;
      valid = 1'b0; alu = MULT;
      dn = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         dn += int'(done) + int'(stall);
      end
      chk("bubble quiet", dn, 0);
      chk("result held", result, 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
